// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles little-endian 32-bit words from a
// byte stream and writes them at sequential word addresses. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              csum_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W:0]   target_reg, target_next;
  logic [ADDR_W:0]   word_cnt_reg, word_cnt_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [31:0]       asm_reg, asm_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              hold_reg, hold_next;

  logic              xfer;
  logic              last_byte;
  logic [ADDR_W:0]   clamped;
  logic [ADDR_W:0]   word_cnt_inc;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_reg, sum_next;
  logic              csum_err_reg, csum_err_next;
  logic              mismatch;

  assign byte_ready = (state_reg == S_RECV) || (state_reg == S_CHECK);
  assign csum_err   = csum_err_reg;
  assign mismatch   = (asm_next != sum_reg);
`else
  assign byte_ready = (state_reg == S_RECV);
  assign csum_err   = 1'b0;
`endif

  assign mem_we       = (state_reg == S_WRITE);
  assign xfer         = byte_valid && byte_ready;
  assign last_byte    = xfer && (byte_cnt_reg == 2'd3);
  assign clamped      = (num_words > DEPTH) ? DEPTH : num_words;
  assign word_cnt_inc = word_cnt_reg + (ADDR_W+1)'(1);

  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign cpu_hold  = hold_reg;

  // Each accepted byte lands in the lane selected by byte_cnt; other lanes hold.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign asm_next[gi*8 +: 8] = (xfer && (byte_cnt_reg == 2'(gi))) ? byte_in
                                                                     : asm_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    target_next    = target_reg;
    word_cnt_next  = word_cnt_reg;
    byte_cnt_next  = byte_cnt_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    busy_next      = busy_reg;
    done_next      = done_reg;
    hold_next      = hold_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_next       = sum_reg;
    csum_err_next  = csum_err_reg;
`endif

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          target_next   = clamped;
          word_cnt_next = '0;
          byte_cnt_next = 2'd0;
          done_next     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_next      = '0;
          csum_err_next = 1'b0;
`endif
          // An empty image completes immediately and releases the CPU.
          if (clamped == '0) begin
            state_next = S_DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            hold_next  = 1'b0;
          end else begin
            state_next = S_RECV;
            busy_next  = 1'b1;
            hold_next  = 1'b1;
          end
        end
      end

      S_RECV: begin
        if (xfer) begin
          byte_cnt_next = byte_cnt_reg + 2'd1;
        end
        if (last_byte) begin
          state_next     = S_WRITE;
          mem_addr_next  = word_cnt_reg[ADDR_W-1:0];
          mem_wdata_next = asm_next;
        end
      end

      S_WRITE: begin
        word_cnt_next = word_cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_next      = sum_reg + mem_wdata_reg;
`endif
        if (word_cnt_inc == target_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_DONE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          hold_next  = 1'b0;
`endif
        end else begin
          state_next = S_RECV;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          byte_cnt_next = byte_cnt_reg + 2'd1;
        end
        // A bad image keeps the CPU held even though the load has finished.
        if (last_byte) begin
          state_next    = S_DONE;
          csum_err_next = mismatch;
          done_next     = 1'b1;
          busy_next     = 1'b0;
          hold_next     = mismatch;
        end
      end
`endif

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      target_reg    <= '0;
      word_cnt_reg  <= '0;
      byte_cnt_reg  <= 2'd0;
      asm_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      hold_reg      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_reg       <= '0;
      csum_err_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      target_reg    <= target_next;
      word_cnt_reg  <= word_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
      asm_reg       <= asm_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      hold_reg      <= hold_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_reg       <= sum_next;
      csum_err_reg  <= csum_err_next;
`endif
    end
  end

endmodule
